// File: rtl/run_ctrl.sv
// run_ctrl: sequences a multi-pass compute engine for one run.
// A run starts on an enable pulse in IDLE. Each pass issues one eng_start pulse
// and then waits for eng_done. After the last pass the block raises valid for
// one cycle. A run that exceeds its cycle budget is aborted through ERR, which
// sets a sticky timeout flag.
module run_ctrl #(
  parameter int unsigned NUM_PASSES     = 4,        // engine passes per run, 1..255
  parameter int unsigned TIMEOUT_CYCLES = 1000000   // run cycle budget, 2..2^32-1
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic        enable,
  output logic        valid,
  output logic        busy,
  output logic        eng_start,
  input  logic        eng_done,
  output logic [7:0]  pass_idx,
  output logic [31:0] cycle_cnt,
  output logic        timeout
);

  localparam logic [7:0]  LAST_PASS   = 8'(NUM_PASSES - 1);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_pass_idx;
  logic [31:0] r_cycle_cnt;
  logic        r_timeout;

  // Run sequencing: state, pass index, cycle counter and sticky abort flag.
  // NOTE: every register here clears on the asynchronous reset edge, so the
  // outputs drop the moment srst_n falls, with no clock needed.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_state     <= S_IDLE;
      r_pass_idx  <= '0;
      r_cycle_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below
      // sees the values held at the start of the cycle.
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state     <= S_START;
            r_pass_idx  <= '0;
            r_cycle_cnt <= '0;
            r_timeout   <= 1'b0;
          end
        end

        S_START: begin
          r_cycle_cnt <= r_cycle_cnt + 32'd1;
          r_state     <= S_WAIT;
        end

        S_WAIT: begin
          r_cycle_cnt <= r_cycle_cnt + 32'd1;
          // A pass completion takes priority over an expired budget.
          if (eng_done) begin
            if (r_pass_idx == LAST_PASS) begin
              r_state <= S_DONE;
            end else begin
              r_pass_idx <= r_pass_idx + 8'd1;
              r_state    <= S_START;
            end
          end else if (r_cycle_cnt >= TIMEOUT_LIM) begin
            r_timeout <= 1'b1;
            r_state   <= S_ERR;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        S_ERR: begin
          r_timeout <= 1'b1;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of the state register and the held registers.
  assign busy      = (r_state != S_IDLE);
  assign eng_start = (r_state == S_START);
  assign valid     = (r_state == S_DONE);
  assign pass_idx  = r_pass_idx;
  assign cycle_cnt = r_cycle_cnt;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed scenarios for run_ctrl with hand-computed expectations.
// Four instances cover the parameter sets the scenarios need:
//   a: NUM_PASSES=2, default budget   b: NUM_PASSES=4, default budget
//   c: NUM_PASSES=2, budget 20        d: NUM_PASSES=2, budget 6
// Cycle 0 is the cycle in which enable is high; cycle 1 follows its edge.
module tb_run_ctrl;

  logic clk;
  logic srst_n;

  logic en_a, done_a, valid_a, busy_a, start_a, to_a;
  logic [7:0] pidx_a;
  logic [31:0] cnt_a;
  logic en_b, done_b, valid_b, busy_b, start_b, to_b;
  logic [7:0] pidx_b;
  logic [31:0] cnt_b;
  logic en_c, done_c, valid_c, busy_c, start_c, to_c;
  logic [7:0] pidx_c;
  logic [31:0] cnt_c;
  logic en_d, done_d, valid_d, busy_d, start_d, to_d;
  logic [7:0] pidx_d;
  logic [31:0] cnt_d;

  int tests_run = 0;
  int failed    = 0;

  run_ctrl #(.NUM_PASSES(2)) u_a (
    .clk(clk), .srst_n(srst_n), .enable(en_a), .valid(valid_a), .busy(busy_a),
    .eng_start(start_a), .eng_done(done_a), .pass_idx(pidx_a), .cycle_cnt(cnt_a),
    .timeout(to_a)
  );

  run_ctrl #(.NUM_PASSES(4)) u_b (
    .clk(clk), .srst_n(srst_n), .enable(en_b), .valid(valid_b), .busy(busy_b),
    .eng_start(start_b), .eng_done(done_b), .pass_idx(pidx_b), .cycle_cnt(cnt_b),
    .timeout(to_b)
  );

  run_ctrl #(.NUM_PASSES(2), .TIMEOUT_CYCLES(20)) u_c (
    .clk(clk), .srst_n(srst_n), .enable(en_c), .valid(valid_c), .busy(busy_c),
    .eng_start(start_c), .eng_done(done_c), .pass_idx(pidx_c), .cycle_cnt(cnt_c),
    .timeout(to_c)
  );

  run_ctrl #(.NUM_PASSES(2), .TIMEOUT_CYCLES(6)) u_d (
    .clk(clk), .srst_n(srst_n), .enable(en_d), .valid(valid_d), .busy(busy_d),
    .eng_start(start_d), .eng_done(done_d), .pass_idx(pidx_d), .cycle_cnt(cnt_d),
    .timeout(to_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst_n = 1'b0;
    en_a = 0; done_a = 0; en_b = 0; done_b = 0;
    en_c = 0; done_c = 0; en_d = 0; done_d = 0;
    #2;
    tests_run++; if (busy_a !== 1'b0)   begin failed++; $display("FAIL reset_busy: got %0b want 0", busy_a); end
    tests_run++; if (valid_a !== 1'b0)  begin failed++; $display("FAIL reset_valid: got %0b want 0", valid_a); end
    tests_run++; if (start_a !== 1'b0)  begin failed++; $display("FAIL reset_eng_start: got %0b want 0", start_a); end
    tests_run++; if (pidx_a !== 8'd0)   begin failed++; $display("FAIL reset_pass_idx: got %0d want 0", pidx_a); end
    tests_run++; if (cnt_a !== 32'd0)   begin failed++; $display("FAIL reset_cycle_cnt: got %0d want 0", cnt_a); end
    tests_run++; if (to_a !== 1'b0)     begin failed++; $display("FAIL reset_timeout: got %0b want 0", to_a); end
    tick();
    tick();
    @(negedge clk);
    srst_n = 1'b1;
    tick();
    tests_run++; if (busy_a !== 1'b0)   begin failed++; $display("FAIL reset_idle_after_release: busy got %0b want 0", busy_a); end
  endtask

  // NUM_PASSES=2, eng_done in the first WAIT cycle of each pass.
  task automatic test_min_latency();
    logic e_start, e_valid, e_busy;
    en_a = 1; tick(); en_a = 0;
    for (int c = 1; c <= 7; c++) begin
      e_start = (c == 1 || c == 3);
      e_valid = (c == 5);
      e_busy  = (c <= 5);
      tests_run++; if (start_a !== e_start) begin failed++; $display("FAIL minlat_eng_start c%0d: got %0b want %0b", c, start_a, e_start); end
      tests_run++; if (valid_a !== e_valid) begin failed++; $display("FAIL minlat_valid c%0d: got %0b want %0b", c, valid_a, e_valid); end
      tests_run++; if (busy_a !== e_busy)   begin failed++; $display("FAIL minlat_busy c%0d: got %0b want %0b", c, busy_a, e_busy); end
      if (c == 5) begin
        tests_run++; if (cnt_a !== 32'd4) begin failed++; $display("FAIL minlat_cycle_cnt: got %0d want 4", cnt_a); end
        tests_run++; if (pidx_a !== 8'd1) begin failed++; $display("FAIL minlat_pass_idx: got %0d want 1", pidx_a); end
        tests_run++; if (to_a !== 1'b0)   begin failed++; $display("FAIL minlat_timeout: got %0b want 0", to_a); end
      end
      done_a = (c == 2 || c == 4);
      tick();
      done_a = 0;
    end
    tests_run++; if (cnt_a !== 32'd4) begin failed++; $display("FAIL minlat_cnt_held: got %0d want 4", cnt_a); end
  endtask

  // Stray enables and eng_done pulses in IDLE, START and DONE must be ignored.
  task automatic test_ignored_inputs();
    logic [8:0] en_v    = 9'b001010111;
    logic [8:0] done_v  = 9'b011111011;
    logic [8:0] start_v = 9'b000010010;
    logic [8:0] valid_v = 9'b001000000;
    logic [8:0] busy_v  = 9'b001111110;
    logic [8:0] pidx_v  = 9'b111110001;
    for (int c = 0; c <= 8; c++) begin
      tests_run++; if (start_a !== start_v[c]) begin failed++; $display("FAIL ignore_eng_start c%0d: got %0b want %0b", c, start_a, start_v[c]); end
      tests_run++; if (valid_a !== valid_v[c]) begin failed++; $display("FAIL ignore_valid c%0d: got %0b want %0b", c, valid_a, valid_v[c]); end
      tests_run++; if (busy_a !== busy_v[c])   begin failed++; $display("FAIL ignore_busy c%0d: got %0b want %0b", c, busy_a, busy_v[c]); end
      tests_run++; if (pidx_a !== {7'd0, pidx_v[c]}) begin failed++; $display("FAIL ignore_pass_idx c%0d: got %0d want %0d", c, pidx_a, pidx_v[c]); end
      en_a   = en_v[c];
      done_a = done_v[c];
      tick();
    end
    en_a = 0; done_a = 0;
    tests_run++; if (cnt_a !== 32'd5) begin failed++; $display("FAIL ignore_cycle_cnt: got %0d want 5", cnt_a); end
  endtask

  // NUM_PASSES=4, eng_done in the tenth WAIT cycle of every pass.
  task automatic test_delayed_done();
    int starts = 0, valids = 0, last_start = -100, valid_cyc = -1;
    en_b = 1; tick(); en_b = 0;
    for (int c = 1; c <= 60; c++) begin
      if (start_b === 1'b1) begin starts++; last_start = c; end
      if (valid_b === 1'b1) begin
        valids++; valid_cyc = c;
        tests_run++; if (cnt_b !== 32'd44) begin failed++; $display("FAIL delay_cycle_cnt: got %0d want 44", cnt_b); end
        tests_run++; if (pidx_b !== 8'd3)  begin failed++; $display("FAIL delay_pass_idx: got %0d want 3", pidx_b); end
      end
      done_b = (c == last_start + 10);
      tick();
      done_b = 0;
    end
    tests_run++; if (starts !== 4)     begin failed++; $display("FAIL delay_start_count: got %0d want 4", starts); end
    tests_run++; if (valids !== 1)     begin failed++; $display("FAIL delay_valid_count: got %0d want 1", valids); end
    tests_run++; if (valid_cyc !== 45) begin failed++; $display("FAIL delay_valid_cycle: got %0d want 45", valid_cyc); end
    tests_run++; if (to_b !== 1'b0)    begin failed++; $display("FAIL delay_timeout: got %0b want 0", to_b); end
  endtask

  // Budget 20, eng_done never arrives: abort, sticky flag, then cleared by a new run.
  task automatic test_timeout();
    int vcount = 0;
    en_c = 1; tick(); en_c = 0;
    for (int c = 1; c <= 25; c++) begin
      if (valid_c === 1'b1) vcount++;
      if (c == 21) begin
        tests_run++; if (cnt_c !== 32'd20) begin failed++; $display("FAIL tmo_cnt_at_limit: got %0d want 20", cnt_c); end
        tests_run++; if (to_c !== 1'b0)    begin failed++; $display("FAIL tmo_early_flag: got %0b want 0", to_c); end
        tests_run++; if (busy_c !== 1'b1)  begin failed++; $display("FAIL tmo_busy_wait: got %0b want 1", busy_c); end
      end
      if (c == 22) begin
        tests_run++; if (to_c !== 1'b1)    begin failed++; $display("FAIL tmo_flag_set: got %0b want 1", to_c); end
        tests_run++; if (busy_c !== 1'b1)  begin failed++; $display("FAIL tmo_busy_err: got %0b want 1", busy_c); end
      end
      if (c == 23) begin
        tests_run++; if (busy_c !== 1'b0)  begin failed++; $display("FAIL tmo_busy_idle: got %0b want 0", busy_c); end
        tests_run++; if (cnt_c !== 32'd21) begin failed++; $display("FAIL tmo_cnt_final: got %0d want 21", cnt_c); end
      end
      if (c == 25) begin
        tests_run++; if (to_c !== 1'b1)    begin failed++; $display("FAIL tmo_sticky: got %0b want 1", to_c); end
      end
      tick();
    end
    tests_run++; if (vcount !== 0) begin failed++; $display("FAIL tmo_no_valid: got %0d pulses want 0", vcount); end
    en_c = 1; tick(); en_c = 0;
    tests_run++; if (to_c !== 1'b0)    begin failed++; $display("FAIL tmo_clear_flag: got %0b want 0", to_c); end
    tests_run++; if (cnt_c !== 32'd0)  begin failed++; $display("FAIL tmo_clear_cnt: got %0d want 0", cnt_c); end
    tests_run++; if (start_c !== 1'b1) begin failed++; $display("FAIL tmo_restart: got %0b want 1", start_c); end
    tick();
    done_c = 1; tick(); done_c = 0;
    tick();
    done_c = 1; tick(); done_c = 0;
    tests_run++; if (valid_c !== 1'b1) begin failed++; $display("FAIL tmo_rerun_valid: got %0b want 1", valid_c); end
    tick();
  endtask

  // Budget 6, eng_done lands in the cycle cycle_cnt reaches 6: done wins.
  task automatic test_done_wins();
    en_d = 1; tick(); en_d = 0;
    for (int i = 0; i < 6; i++) tick();
    tests_run++; if (cnt_d !== 32'd6)  begin failed++; $display("FAIL win_cnt_at_limit: got %0d want 6", cnt_d); end
    done_d = 1; tick(); done_d = 0;
    tests_run++; if (start_d !== 1'b1) begin failed++; $display("FAIL win_next_pass_start: got %0b want 1", start_d); end
    tests_run++; if (pidx_d !== 8'd1)  begin failed++; $display("FAIL win_pass_idx: got %0d want 1", pidx_d); end
    tests_run++; if (to_d !== 1'b0)    begin failed++; $display("FAIL win_timeout: got %0b want 0", to_d); end
    tick();
    tests_run++; if (cnt_d !== 32'd8)  begin failed++; $display("FAIL win_cnt_wait: got %0d want 8", cnt_d); end
    done_d = 1; tick(); done_d = 0;
    tests_run++; if (valid_d !== 1'b1) begin failed++; $display("FAIL win_valid: got %0b want 1", valid_d); end
    tests_run++; if (to_d !== 1'b0)    begin failed++; $display("FAIL win_final_timeout: got %0b want 0", to_d); end
    tests_run++; if (cnt_d !== 32'd9)  begin failed++; $display("FAIL win_final_cnt: got %0d want 9", cnt_d); end
    tick();
  endtask

  // Reset pulsed off-edge during WAIT of the second pass, then a clean rerun.
  task automatic test_reset_mid_run();
    en_a = 1; tick(); en_a = 0;
    tick();
    done_a = 1; tick(); done_a = 0;
    tick();
    tests_run++; if (pidx_a !== 8'd1 || cnt_a !== 32'd3) begin failed++; $display("FAIL rst_pre_state: pass_idx %0d cnt %0d want 1 3", pidx_a, cnt_a); end
    #3;
    srst_n = 1'b0;
    #1;
    tests_run++; if (busy_a !== 1'b0)  begin failed++; $display("FAIL rst_async_busy: got %0b want 0", busy_a); end
    tests_run++; if (pidx_a !== 8'd0)  begin failed++; $display("FAIL rst_async_pass_idx: got %0d want 0", pidx_a); end
    tests_run++; if (cnt_a !== 32'd0)  begin failed++; $display("FAIL rst_async_cycle_cnt: got %0d want 0", cnt_a); end
    tests_run++; if (start_a !== 1'b0 || valid_a !== 1'b0 || to_a !== 1'b0) begin failed++; $display("FAIL rst_async_flags: start %0b valid %0b timeout %0b want 0 0 0", start_a, valid_a, to_a); end
    tick();
    tests_run++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin failed++; $display("FAIL rst_held: valid %0b busy %0b want 0 0", valid_a, busy_a); end
    #2;
    srst_n = 1'b1;
    en_a = 1; tick(); en_a = 0;
    tests_run++; if (start_a !== 1'b1) begin failed++; $display("FAIL rst_first_edge_accept: got %0b want 1", start_a); end
    tick();
    done_a = 1; tick(); done_a = 0;
    tick();
    done_a = 1; tick(); done_a = 0;
    tests_run++; if (valid_a !== 1'b1) begin failed++; $display("FAIL rst_rerun_valid: got %0b want 1", valid_a); end
    tests_run++; if (cnt_a !== 32'd4)  begin failed++; $display("FAIL rst_rerun_cnt: got %0d want 4", cnt_a); end
    tick();
    tests_run++; if (busy_a !== 1'b0)  begin failed++; $display("FAIL rst_rerun_idle: got %0b want 0", busy_a); end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_ignored_inputs();
    test_delayed_done();
    test_timeout();
    test_done_wins();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  // Bound the whole run in case the design stalls somewhere unexpected.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
